fp_add_scheduler: RTL and testbench
===================================

// Module: fp_add_scheduler
// PURPOSE
//  Shares one multi-cycle IEEE-754 single-precision adder core between two requesters.
//  Round-robin arbitrates, latches operands, and consults the special-case unit first.
//  Special operands (zero/inf/NaN) resolve on the fast path; otherwise the block starts
//  the adder and waits for done, with a watchdog. Returns the result with a requester tag.
// PARAMETERS
//  TIMEOUT  64                 max cycles in WAIT before abort; must be >= 2
//  CNT_W    $clog2(TIMEOUT)    watchdog counter width
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  req0_valid in   1   requester 0 has operands
//  req0_a     in   32  requester 0 operand A
//  req0_b     in   32  requester 0 operand B
//  req0_ready out  1   requester 0 accepted this cycle
//  req1_valid/req1_a/req1_b/req1_ready   same as requester 0
//  sc_a, sc_b out  32  operands to special-case unit (= latched op regs)
//  sc_s       in   32  special-case result
//  sc_enable  in   1   1 = both operands normal/subnormal; adder required
//  add_a, add_b out 32 operands to adder core (= latched op regs)
//  add_start  out  1   one-cycle start pulse
//  add_done   in   1   adder result valid (one-cycle pulse)
//  add_s      in   32  adder result
//  res_valid  out  1   result available
//  res_ready  in   1   consumer accepts result
//  res_s      out  32  result word
//  res_tag    out  1   requester id of result
//  res_err    out  1   1 = watchdog abort, res_s = 32'h7FC00000
// BEHAVIOUR
//  - Reset: state IDLE; req*_ready, add_start, res_valid, res_err = 0; res_s = 0;
//    res_tag = 0; op regs = 0; last_grant = 1 (req0 wins first tie).
//  - FSM IDLE -> CHECK -> (WAIT) -> RESP -> IDLE. One operation in flight.
//  - IDLE: if any valid, grant: single valid wins; both valid -> requester != last_grant.
//    req<g>_ready = 1 combinationally in IDLE for the granted requester only; on that edge
//    latch a/b/tag, go CHECK. req*_ready = 0 in every other state.
//  - CHECK (1 cycle): if fast path applies (sc_enable == 0): res_s <= sc_s, go RESP,
//    add_start stays 0. Else add_start = 1 this cycle only, clear counter, go WAIT.
//  - WAIT: add_done -> res_s <= add_s, res_err <= 0, go RESP. Else counter++;
//    counter == TIMEOUT-1 without done -> res_s <= 32'h7FC00000, res_err <= 1, go RESP.
//    done and timeout in the same cycle: done wins. add_done outside WAIT is ignored.
//  - RESP: res_valid = 1; res_s/res_tag/res_err stable until res_valid && res_ready;
//    on handshake last_grant <= res_tag, res_valid drops next cycle, go IDLE.
//    Earliest re-accept: the cycle after the handshake (no same-cycle overlap).
//  - Latency (accept edge = cycle 0): fast path res_valid at cycle 2; adder path
//    add_start at cycle 1, done at cycle 1+k -> res_valid at cycle 2+k.
//  - rst mid-operation: operation abandoned, no result emitted, FSM to IDLE;
//    adder core shares rst, so stale add_done is not expected and is ignored.
//  - Watchdog counter saturates; never wraps.
// CONFIGURATION
//  FP_SCHED_BYPASS_EN defined: fast path as above (special operands never use adder).
//  Undefined: sc_enable ignored; every operation starts the adder, res_s always from add_s
//    (or the timeout NaN). sc_a/sc_b ports remain, driven identically.
// TESTING
//  1 Both valid after reset, A=3F800000 B=40000000, sc_enable=1, add_done 3 cycles after
//    start with 40400000 -> req0_ready first, res_tag=0, res_s=40400000 at cycle 5.
//  2 BYPASS_EN: A=7F800000 B=3F800000, sc_enable=0, sc_s=7F800000 -> add_start never high,
//    res_valid at cycle 2, res_s=7F800000; without macro -> add_start pulses at cycle 1.
//  3 add_done never asserted, TIMEOUT=64 -> res_valid after 64 WAIT cycles,
//    res_s=7FC00000, res_err=1; later done pulse ignored.
//  4 res_ready low 10 cycles in RESP -> res_s/res_tag held, req*_ready stay 0.
//  5 Both requesters continuously valid, 4 ops -> res_tag sequence 0,1,0,1.
//  6 rst asserted in WAIT -> next cycle all outputs 0, state IDLE; add_done then -> no result.

Source files
------------

// File: rtl/fp_add_scheduler.sv
// ============================================================================
// fp_add_scheduler
//
// Shares one multi-cycle single-precision adder core between two requesters.
// A round-robin arbiter grants one requester in IDLE and the block latches its
// operands. A CHECK cycle then either takes the special-case result (fast
// path) or starts the adder. In WAIT the block waits for the adder's done
// pulse, guarded by a watchdog. RESP holds the tagged result until the
// consumer accepts it. Only one operation is in flight at a time.
//
// Configuration macro: FP_SCHED_BYPASS_EN
//   defined   : sc_enable == 0 resolves through the special-case unit (sc_s)
//               and the adder is never started for that operation.
//   undefined : sc_enable and sc_s are ignored; every operation uses the adder.
//
// Parameters
//   TIMEOUT  maximum number of WAIT cycles before abort (>= 2)
//   CNT_W    watchdog counter width
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/_a/_b/_ready   requester 0 operand handshake
//   req1_valid/_a/_b/_ready   requester 1 operand handshake
//   sc_a, sc_b, sc_s          special-case unit operands / result
//   sc_enable                 1 = operands are normal/subnormal, adder needed
//   add_a, add_b, add_start   adder core operands and one-cycle start pulse
//   add_done, add_s           adder core done pulse and result
//   res_valid/res_ready       result handshake
//   res_s, res_tag, res_err   result word, requester id, watchdog-abort flag
// ============================================================================
module fp_add_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic [31:0] sc_a,
    output logic [31:0] sc_b,
    input  logic [31:0] sc_s,
    input  logic        sc_enable,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_start,
    input  logic        add_done,
    input  logic [31:0] add_s,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_s,
    output logic        res_tag,
    output logic        res_err
);

    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             tag_q, tag_d;
    logic             last_grant_q, last_grant_d;
    logic [31:0]      res_s_q, res_s_d;
    logic             res_err_q, res_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic any_valid;
    logic grant_id;
    logic fast_path;
    logic timeout_hit;

`ifdef FP_SCHED_BYPASS_EN
    // Special operands (zero/inf/NaN) never need the adder.
    assign fast_path = ~sc_enable;
`else
    // Special-case inputs are not consulted in this build.
    logic unused_bypass;
    assign fast_path     = 1'b0;
    assign unused_bypass = ^{sc_enable, sc_s};
`endif

    // Round-robin: a lone requester always wins; on a tie the requester that
    // was not served last wins. last_grant resets to 1 so req0 wins first.
    assign any_valid   = req0_valid | req1_valid;
    assign grant_id    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign timeout_hit = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            tag_q        <= 1'b0;
            last_grant_q <= 1'b1;
            res_s_q      <= '0;
            res_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            tag_q        <= tag_d;
            last_grant_q <= last_grant_d;
            res_s_q      <= res_s_d;
            res_err_q    <= res_err_d;
            cnt_q        <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        tag_d        = tag_q;
        last_grant_d = last_grant_q;
        res_s_d      = res_s_q;
        res_err_d    = res_err_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    op_a_d  = grant_id ? req1_a : req0_a;
                    op_b_d  = grant_id ? req1_b : req0_b;
                    tag_d   = grant_id;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (fast_path) begin
                    res_s_d   = sc_s;
                    res_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done pulse in the same cycle as the timeout wins.
                if (add_done) begin
                    res_s_d   = add_s;
                    res_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (timeout_hit) begin
                    res_s_d   = QNAN;
                    res_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    last_grant_d = tag_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        add_start  = 1'b0;
        res_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req0_ready = any_valid & ~grant_id;
                req1_ready = any_valid &  grant_id;
            end
            ST_CHECK: add_start = ~fast_path;
            ST_RESP:  res_valid = 1'b1;
            default: ;
        endcase
    end

    assign sc_a    = op_a_q;
    assign sc_b    = op_b_q;
    assign add_a   = op_a_q;
    assign add_b   = op_b_q;
    assign res_s   = res_s_q;
    assign res_tag = tag_q;
    assign res_err = res_err_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// ============================================================================
// tb_fp_add_scheduler
//
// Self-checking bench for fp_add_scheduler. A behavioural adder core answers
// add_start after a programmable latency. Expected results are queued when a
// request is accepted and compared when the consumer handshake occurs.
// ============================================================================
module tb_fp_add_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [31:0] sc_a, sc_b, sc_s;
    logic        sc_enable;
    logic [31:0] add_a, add_b, add_s;
    logic        add_start, add_done;
    logic        res_valid, res_ready;
    logic [31:0] res_s;
    logic        res_tag, res_err;

    typedef struct packed {
        logic        tag;
        logic [31:0] s;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural adder controls
    int          add_lat      = 3;
    logic [31:0] add_res      = 32'h0;
    logic        add_sum_mode = 1'b0;

    always #5 clk = ~clk;

    fp_add_scheduler #(.TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .sc_a       (sc_a),
        .sc_b       (sc_b),
        .sc_s       (sc_s),
        .sc_enable  (sc_enable),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_start  (add_start),
        .add_done   (add_done),
        .add_s      (add_s),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_s      (res_s),
        .res_tag    (res_tag),
        .res_err    (res_err)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Adder core model: start seen in cycle c, done pulses in cycle c+add_lat.
    initial begin
        logic [31:0] a, b;
        add_done = 1'b0;
        add_s    = 32'h0;
        forever begin
            @(negedge clk);
            if (add_start && !rst) begin
                a = add_a;
                b = add_b;
                repeat (add_lat) @(posedge clk);
                #1;
                add_done = 1'b1;
                add_s    = add_sum_mode ? (a + b) : add_res;
                @(posedge clk);
                #1;
                add_done = 1'b0;
            end
        end
    end

    // Scoreboard: compare each accepted result against the queued expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            $display("result tag=%0d s=%h err=%0d", res_tag, res_s, res_err);
            if (exp_q.size() == 0) begin
                check_value("spurious_result", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_value("res_tag", 32'(res_tag), 32'(e.tag));
                check_value("res_s",   res_s,        e.s);
                check_value("res_err", 32'(res_err), 32'(e.err));
            end
        end
    end

    // Drive one request (one or both requesters with the same operands),
    // queue the expectation, then follow it until res_valid, checking latency
    // and the cycle of add_start (-1 = never). Returns at the negedge of the
    // first res_valid cycle.
    task automatic do_op(input logic v0, input logic v1,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic exp_tag, input logic [31:0] exp_s,
                         input logic exp_err, input int exp_lat, input int exp_start);
        int   n;
        int   start_at;
        logic got;
        exp_t e;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a; req0_b = b;
        req1_valid = v1; req1_a = a; req1_b = b;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_tag ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        check_value("grant_ready", 32'(got), 32'd1);
        if (!got) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        check_value("other_ready", 32'(exp_tag ? req0_ready : req1_ready), 32'd0);
        e.tag = exp_tag; e.s = exp_s; e.err = exp_err;
        exp_q.push_back(e);
        $display("issue tag=%0d a=%h b=%h", exp_tag, a, b);
        @(posedge clk);            // accept edge = cycle 0
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        start_at = -1;
        n = 1;
        got = 1'b0;
        while (n < 120) begin
            @(negedge clk);
            if (add_start && start_at < 0) start_at = n;
            if (n == 1) begin
                check_value("sc_a_latched",  sc_a,  a);
                check_value("add_b_latched", add_b, b);
            end
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        check_value("res_valid_seen", 32'(got), 32'd1);
        check_value("latency", 32'(n), 32'(exp_lat));
        check_value("start_cycle", 32'(start_at), 32'(exp_start));
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        sc_s = '0; sc_enable = 1'b1; res_ready = 1'b1;

        // ---- Reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_req0_ready", 32'(req0_ready), 32'd0);
        check_value("rst_req1_ready", 32'(req1_ready), 32'd0);
        check_value("rst_add_start",  32'(add_start),  32'd0);
        check_value("rst_res_valid",  32'(res_valid),  32'd0);
        check_value("rst_res_err",    32'(res_err),    32'd0);
        check_value("rst_res_tag",    32'(res_tag),    32'd0);
        check_value("rst_res_s",      res_s,           32'd0);
        check_value("rst_sc_a",       sc_a,            32'd0);
        check_value("rst_add_b",      add_b,           32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- T1: tie after reset -> req0, adder done 3 cycles after start ----
        add_lat = 3; add_res = 32'h4040_0000; sc_enable = 1'b1;
        do_op(1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 5, 1);

        // ---- T2: special operand (inf + 1) ----
        sc_enable = 1'b0; sc_s = 32'h7F80_0000;
        add_lat = 2; add_res = 32'h7F80_0000;
`ifdef FP_SCHED_BYPASS_EN
        do_op(1'b0, 1'b1, 32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 1'b0, 2, -1);
`else
        do_op(1'b0, 1'b1, 32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 1'b0, 4, 1);
`endif

        // ---- T3: watchdog abort after 64 WAIT cycles; late done ignored ----
        sc_enable = 1'b1; sc_s = '0;
        add_lat = 70; add_res = 32'h1234_5678;
        do_op(1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1, 66, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_value("late_done_ignored", 32'(res_valid), 32'd0);
        end

        // ---- T4: consumer stalls 10 cycles in RESP ----
        add_lat = 2; add_res = 32'h4100_0000;
        res_ready = 1'b0;
        do_op(1'b0, 1'b1, 32'h4080_0000, 32'h4080_0000, 1'b1, 32'h4100_0000, 1'b0, 4, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_value("hold_res_valid",  32'(res_valid),  32'd1);
            check_value("hold_res_s",      res_s,           32'h4100_0000);
            check_value("hold_res_tag",    32'(res_tag),    32'd1);
            check_value("hold_req0_ready", 32'(req0_ready), 32'd0);
            check_value("hold_req1_ready", 32'(req1_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);            // handshake edge
        @(negedge clk);
        check_value("post_hs_res_valid", 32'(res_valid), 32'd0);
        check_value("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---- T6: reset while waiting on the adder; stale done ignored ----
        add_lat = 10; sc_enable = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
        @(negedge clk);
        check_value("t6_req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);            // accept edge
        #1 req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;             // state is WAIT here
        @(posedge clk);
        @(negedge clk);
        check_value("t6_req0_ready0", 32'(req0_ready), 32'd0);
        check_value("t6_add_start0",  32'(add_start),  32'd0);
        check_value("t6_res_valid0",  32'(res_valid),  32'd0);
        check_value("t6_res_s0",      res_s,           32'd0);
        check_value("t6_res_err0",    32'(res_err),    32'd0);
        check_value("t6_sc_a0",       sc_a,            32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_value("t6_no_result", 32'(res_valid), 32'd0);
            check_value("t6_no_start",  32'(add_start), 32'd0);
        end

        // ---- T5: both requesters continuously valid, 4 operations ----
        add_lat = 1; add_sum_mode = 1'b1; sc_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.tag = i[0];
            e.s   = i[0] ? 32'h0000_2002 : 32'h0000_1001;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 32'h0000_1000; req0_b = 32'h0000_0001;
        req1_valid = 1'b1; req1_a = 32'h0000_2000; req1_b = 32'h0000_0002;
        begin
            int n = 0;
            while (n < 200) begin
                @(negedge clk);
                #1;
                if (exp_q.size() == 0) break;
                n++;
            end
            check_value("t5_all_results", 32'(exp_q.size()), 32'd0);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_value("t5_idle_after", 32'(res_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "bench timeout");
    end

endmodule
